// File: rtl/controle_temporizador_pkg.sv
// Shared types and helpers for the mm:ss BCD countdown timer.
// Optional feature macro: AUTO_RELOAD_EN (see controle_temporizador.sv).
package controle_temporizador_pkg;

  localparam int DIGIT_W   = 4;
  localparam int UNITS_MOD = 10;
  localparam int TIME_W    = 4 * DIGIT_W;

  // Packing: {min_tens, min_units, sec_tens, sec_units}
  typedef logic [TIME_W-1:0] bcd_time_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [DIGIT_W-1:0] clampDigit(input logic [DIGIT_W-1:0] d,
                                                    input int modulus);
    if (int'(d) >= modulus) return DIGIT_W'(modulus - 1);
    return d;
  endfunction

  function automatic bcd_time_t clampPreset(input bcd_time_t p, input int tensMod);
    bcd_time_t r;
    r[3:0]   = clampDigit(p[3:0],   UNITS_MOD);
    r[7:4]   = clampDigit(p[7:4],   tensMod);
    r[11:8]  = clampDigit(p[11:8],  UNITS_MOD);
    r[15:12] = clampDigit(p[15:12], tensMod);
    return r;
  endfunction

endpackage

// File: rtl/controle_temporizador_if.sv
// Control/data bundle of the countdown timer; master drives commands, slave is the timer.
interface controle_temporizador_if;
  import controle_temporizador_pkg::*;

  logic      tick;
  logic      load;
  logic      start;
  logic      pause;
  bcd_time_t preset;
  bcd_time_t vetor;
  logic      running;
  logic      done;
  logic      zero_pulse;

  modport master (
    output tick, load, start, pause, preset,
    input  vetor, running, done, zero_pulse
  );

  modport slave (
    input  tick, load, start, pause, preset,
    output vetor, running, done, zero_pulse
  );

endinterface

// File: rtl/controle_temporizador_bcd_digit_down.sv
// One BCD down-counting digit with parallel load; borrow_o flags a decrement taken at zero.
module bcd_digit_down
  import controle_temporizador_pkg::*;
#(
  parameter int MODULUS = UNITS_MOD
)
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               borrow_o
);

  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] digitQ;
  logic [DIGIT_W-1:0] digitD;

  always_comb begin
    digitD = digitQ;
    if (load_i) begin
      digitD = load_val_i;
    end else if (dec_i) begin
      digitD = (digitQ == '0) ? TOP : digitQ - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digitQ <= '0;
    end else begin
      digitQ <= digitD;
    end
  end

  assign digit_o  = digitQ;
  assign borrow_o = dec_i && !load_i && (digitQ == '0);

endmodule

// File: rtl/controle_temporizador.sv
// mm:ss BCD countdown timer with IDLE/RUN/PAUSE/DONE control.
// Define AUTO_RELOAD_EN to restart from the last loaded preset when the count expires.
module controle_temporizador
  import controle_temporizador_pkg::*;
#(
  parameter int TENS_MOD = 6
)
(
  input logic                   clock_i,
  input logic                   reset_i,
  controle_temporizador_if.slave bus
);

  state_e    stateQ;
  state_e    stateD;
  logic      zeroPulseQ;
  logic      zeroPulseD;
  logic      decEn;
  logic      reloadNow;
  logic      loadDigits;
  bcd_time_t presetClamped;
  bcd_time_t loadVal;
  bcd_time_t count;
  logic      countIsZero;
  logic      countIsOne;
  logic      borrowSu;
  logic      borrowSt;
  logic      borrowMu;
  logic      borrowMt;

  assign presetClamped = clampPreset(bus.preset, TENS_MOD);
  assign countIsZero   = (count == '0);
  assign countIsOne    = (count == bcd_time_t'(1));
  assign loadDigits    = bus.load || reloadNow;

`ifdef AUTO_RELOAD_EN
  bcd_time_t reloadQ;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      reloadQ <= '0;
    end else if (bus.load) begin
      reloadQ <= presetClamped;
    end
  end

  assign loadVal = bus.load ? presetClamped : reloadQ;
`else
  assign loadVal = presetClamped;
`endif

  // Seconds-units decrements on decEn; each higher digit steps on the borrow below it.
  bcd_digit_down #(.MODULUS(UNITS_MOD)) uSecUnits (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .load_i     (loadDigits),
    .load_val_i (loadVal[3:0]),
    .dec_i      (decEn),
    .digit_o    (count[3:0]),
    .borrow_o   (borrowSu)
  );

  bcd_digit_down #(.MODULUS(TENS_MOD)) uSecTens (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .load_i     (loadDigits),
    .load_val_i (loadVal[7:4]),
    .dec_i      (borrowSu),
    .digit_o    (count[7:4]),
    .borrow_o   (borrowSt)
  );

  bcd_digit_down #(.MODULUS(UNITS_MOD)) uMinUnits (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .load_i     (loadDigits),
    .load_val_i (loadVal[11:8]),
    .dec_i      (borrowSt),
    .digit_o    (count[11:8]),
    .borrow_o   (borrowMu)
  );

  bcd_digit_down #(.MODULUS(TENS_MOD)) uMinTens (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .load_i     (loadDigits),
    .load_val_i (loadVal[15:12]),
    .dec_i      (borrowMu),
    .digit_o    (count[15:12]),
    .borrow_o   (borrowMt)
  );

  // The FSM only decrements a nonzero count, so the top digit must never borrow.
  assert property (@(posedge clock_i) disable iff (reset_i) !borrowMt);

  always_comb begin
    stateD     = stateQ;
    decEn      = 1'b0;
    reloadNow  = 1'b0;
    zeroPulseD = 1'b0;
    if (bus.load) begin
      stateD = IDLE;
    end else begin
      unique case (stateQ)
        IDLE: begin
          if (bus.start) stateD = countIsZero ? DONE : RUN;
        end
        RUN: begin
          if (bus.pause) begin
            stateD = PAUSE;
          end else if (bus.tick && !countIsZero) begin
            if (countIsOne) begin
              zeroPulseD = 1'b1;
`ifdef AUTO_RELOAD_EN
              if (reloadQ != '0) begin
                reloadNow = 1'b1;
              end else begin
                decEn  = 1'b1;
                stateD = DONE;
              end
`else
              decEn  = 1'b1;
              stateD = DONE;
`endif
            end else begin
              decEn = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (bus.start) stateD = RUN;
        end
        DONE: begin
          stateD = DONE;
        end
        default: stateD = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stateQ     <= IDLE;
      zeroPulseQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      zeroPulseQ <= zeroPulseD;
    end
  end

  assign bus.vetor      = count;
  assign bus.running    = (stateQ == RUN);
  assign bus.done       = (stateQ == DONE);
  assign bus.zero_pulse = zeroPulseQ;

endmodule

// File: tb/tb_controle_temporizador.sv
// Scoreboard bench for controle_temporizador: stimulus queues expected outputs, a monitor compares.
// Expectations for the AUTO_RELOAD_EN build are selected with the same macro.
module tb_controle_temporizador;
  import controle_temporizador_pkg::*;

  typedef struct packed {
    bcd_time_t vetor;
    logic      running;
    logic      done;
    logic      zeroPulse;
  } expect_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  controle_temporizador_if ctIf();

  controle_temporizador #(.TENS_MOD(6)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (ctIf)
  );

  always #5 clock = ~clock;

  expect_t expQ[$];
  string   nameQ[$];
  int      checks = 0;
  int      errors = 0;

  // One cycle of stimulus, driven at the falling edge; the expected state after the next rising edge is queued.
  task automatic applyStimulus(input string name, input logic rstV, input logic loadV,
                               input logic startV, input logic pauseV, input logic tickV,
                               input bcd_time_t presetV, input bcd_time_t expV,
                               input logic expR, input logic expD, input logic expZ);
    expect_t e;
    @(negedge clock);
    reset       = rstV;
    ctIf.load   = loadV;
    ctIf.start  = startV;
    ctIf.pause  = pauseV;
    ctIf.tick   = tickV;
    ctIf.preset = presetV;
    e.vetor     = expV;
    e.running   = expR;
    e.done      = expD;
    e.zeroPulse = expZ;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput();
    expect_t e;
    expect_t a;
    string   n;
    e           = expQ.pop_front();
    n           = nameQ.pop_front();
    a.vetor     = ctIf.vetor;
    a.running   = ctIf.running;
    a.done      = ctIf.done;
    a.zeroPulse = ctIf.zero_pulse;
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got vetor=%h running=%b done=%b zero_pulse=%b, expected vetor=%h running=%b done=%b zero_pulse=%b",
               n, a.vetor, a.running, a.done, a.zeroPulse, e.vetor, e.running, e.done, e.zeroPulse);
    end
  endtask

  // Monitor: the timer presents a new output every cycle, sampled just after the rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) checkOutput();
    end
  end

  initial begin
    int guard;
    ctIf.load   = 1'b0;
    ctIf.start  = 1'b0;
    ctIf.pause  = 1'b0;
    ctIf.tick   = 1'b0;
    ctIf.preset = '0;

    //              name             rst  ld  st  pa  tk  preset     vetor     r  d  z
    applyStimulus("reset",          1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    applyStimulus("idle_tick",      0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    applyStimulus("load_0105",      0, 1, 0, 0, 0, 16'h0105, 16'h0105, 0, 0, 0);
    applyStimulus("start_0105",     0, 0, 1, 0, 0, 16'h0000, 16'h0105, 1, 0, 0);
    applyStimulus("tick_0104",      0, 0, 0, 0, 1, 16'h0000, 16'h0104, 1, 0, 0);
    applyStimulus("tick_0103",      0, 0, 0, 0, 1, 16'h0000, 16'h0103, 1, 0, 0);
    applyStimulus("tick_0102",      0, 0, 0, 0, 1, 16'h0000, 16'h0102, 1, 0, 0);
    applyStimulus("tick_0101",      0, 0, 0, 0, 1, 16'h0000, 16'h0101, 1, 0, 0);
    applyStimulus("tick_0100",      0, 0, 0, 0, 1, 16'h0000, 16'h0100, 1, 0, 0);
    applyStimulus("tick_0059",      0, 0, 0, 0, 1, 16'h0000, 16'h0059, 1, 0, 0);
    applyStimulus("hold_0059",      0, 0, 0, 0, 0, 16'h0000, 16'h0059, 1, 0, 0);
    applyStimulus("load_clamp",     0, 1, 0, 0, 0, 16'hFF7C, 16'h5959, 0, 0, 0);

    applyStimulus("load_1000",      0, 1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
    applyStimulus("start_1000",     0, 0, 1, 0, 0, 16'h0000, 16'h1000, 1, 0, 0);
    applyStimulus("tick_0959",      0, 0, 0, 0, 1, 16'h0000, 16'h0959, 1, 0, 0);
    applyStimulus("tick_0958",      0, 0, 0, 0, 1, 16'h0000, 16'h0958, 1, 0, 0);
    applyStimulus("reset_midrun",   1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);

    applyStimulus("load_0030",      0, 1, 0, 0, 0, 16'h0030, 16'h0030, 0, 0, 0);
    applyStimulus("start_0030",     0, 0, 1, 0, 0, 16'h0000, 16'h0030, 1, 0, 0);
    applyStimulus("pause_and_tick", 0, 0, 0, 1, 1, 16'h0000, 16'h0030, 0, 0, 0);
    applyStimulus("pause_tick_1",   0, 0, 0, 0, 1, 16'h0000, 16'h0030, 0, 0, 0);
    applyStimulus("pause_tick_2",   0, 0, 0, 0, 1, 16'h0000, 16'h0030, 0, 0, 0);
    applyStimulus("pause_tick_3",   0, 0, 0, 0, 1, 16'h0000, 16'h0030, 0, 0, 0);
    applyStimulus("resume",         0, 0, 1, 0, 0, 16'h0000, 16'h0030, 1, 0, 0);
    applyStimulus("tick_0029",      0, 0, 0, 0, 1, 16'h0000, 16'h0029, 1, 0, 0);
    applyStimulus("start_in_run",   0, 0, 1, 0, 0, 16'h0000, 16'h0029, 1, 0, 0);

    applyStimulus("load_tens_max",  0, 1, 0, 0, 0, 16'h6A06, 16'h5906, 0, 0, 0);
    applyStimulus("load_zero",      0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    applyStimulus("start_at_zero",  0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    applyStimulus("done_tick",      0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
    applyStimulus("load_0002",      0, 1, 0, 0, 0, 16'h0002, 16'h0002, 0, 0, 0);
    applyStimulus("start_0002",     0, 0, 1, 0, 0, 16'h0000, 16'h0002, 1, 0, 0);
    applyStimulus("tick_0001",      0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0);
`ifdef AUTO_RELOAD_EN
    applyStimulus("auto_reload",    0, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 1);
    applyStimulus("auto_tick_0001", 0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0);
    applyStimulus("auto_reload_2",  0, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 1);
    applyStimulus("auto_pause",     0, 0, 0, 1, 0, 16'h0000, 16'h0002, 0, 0, 0);
`else
    applyStimulus("tick_0000",      0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1);
    applyStimulus("done_hold_tick", 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
    applyStimulus("done_start",     0, 0, 1, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
    applyStimulus("done_pause",     0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
`endif

    applyStimulus("load_over_start",0, 1, 1, 0, 0, 16'h0003, 16'h0003, 0, 0, 0);
    applyStimulus("load_0001",      0, 1, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
    applyStimulus("start_0001",     0, 0, 1, 0, 0, 16'h0000, 16'h0001, 1, 0, 0);
    applyStimulus("reset_at_0001",  1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    applyStimulus("reload_0001",    0, 1, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
    applyStimulus("restart_0001",   0, 0, 1, 0, 0, 16'h0000, 16'h0001, 1, 0, 0);
    applyStimulus("load_over_tick", 0, 1, 0, 0, 1, 16'h0004, 16'h0004, 0, 0, 0);
    applyStimulus("idle_hold",      0, 0, 0, 0, 0, 16'h0000, 16'h0004, 0, 0, 0);

    guard = 0;
    while (expQ.size() > 0 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d expectations left, expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controle_temporizador.md
CONTROLE_TEMPORIZADOR -- requirements
Module: controle_temporizador

Interface
REQ-001 Parameter TENS_MOD, default 6: modulus of both tens digits (seconds tens, minutes tens).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: clock input 1, rising-edge clock.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clock edge.
REQ-004 tick  input  1  one-cycle 1 Hz enable pulse; one pulse = one second elapsed.
REQ-005 load  input  1  latch preset digits, return to IDLE.
REQ-006 start  input  1  begin or resume countdown.
REQ-007 pause  input  1  suspend countdown.
REQ-008 preset  input  16  BCD {min_tens, min_units, sec_tens, sec_units}, 4 bits each.
REQ-009 vetor  output  16  current count, BCD, same packing as preset.
REQ-010 running  output  1  high only in RUN.
REQ-011 done  output  1  level, high only in DONE.
REQ-012 zero_pulse  output  1  one-cycle pulse on the cycle the count reaches 00:00.

Function
REQ-013 FSM states SHALL be IDLE, RUN, PAUSE, DONE; input priority: reset > load > pause > start > tick.
REQ-014 load in any state SHALL write clamped preset into the count and the reload register and enter IDLE next cycle.
REQ-015 Clamp: units digit >9 -> 9; tens digit >= TENS_MOD -> TENS_MOD-1.
REQ-016 IDLE + start: count nonzero -> RUN; count 00:00 -> DONE, no zero_pulse.
REQ-017 RUN + tick SHALL decrement the count by one second, registered, visible on vetor the cycle after tick is sampled.
REQ-018 Borrow chain: sec_units 0 -> 9 with borrow; sec_tens 0 -> TENS_MOD-1 with borrow; min_units 0 -> 9 with borrow; min_tens decrements on borrow.
REQ-019 RUN + tick at 00:01 SHALL produce 00:00, zero_pulse high for exactly that one cycle, state DONE.
REQ-020 RUN + pause -> PAUSE, no decrement even if tick is high the same cycle; PAUSE + start -> RUN.
REQ-021 tick SHALL be ignored in IDLE, PAUSE, DONE; start ignored in RUN and DONE; pause ignored outside RUN.
REQ-022 DONE SHALL hold 00:00 until load or reset.
REQ-023 Count SHALL never wrap past 00:00 to 59:59.

Reset
REQ-024 On reset: state IDLE, vetor 0x0000, reload register 0x0000, running 0, done 0, zero_pulse 0.
REQ-025 Reset mid-RUN SHALL abort the countdown with no zero_pulse.

Configuration
REQ-026 Macro AUTO_RELOAD_EN defined: at 00:00 from RUN, count reloads the reload register in the same cycle, state stays RUN, zero_pulse fires, done stays 0; a reload value of 00:00 SHALL go to DONE instead.
REQ-027 AUTO_RELOAD_EN undefined: behaviour per REQ-019/REQ-022; no reload logic synthesised.

Structure
REQ-028 Shared package SHALL hold the state enum, digit width (4), units modulus (10), and the 16-bit BCD time typedef.
REQ-029 One sub-module bcd_digit_down: one digit with load, dec enable, parameter modulus, borrow_out when dec at 0; instantiated four times.

Verification
REQ-030 preset 0x0105, load, start, 6 ticks -> vetor 0104,0103,0102,0101,0100,0059; running 1.
REQ-031 preset 0x0002, load, start, 2 ticks -> vetor 0001 then 0000, zero_pulse one cycle, done 1; further ticks/start leave 0000.
REQ-032 RUN at 0030, tick and pause same cycle -> vetor stays 0030, state PAUSE; 3 ticks no change; start + tick -> 0029.
REQ-033 preset 0xFF7C -> vetor 5959 after load (clamped).
REQ-034 RUN at 1000, tick -> 0959; reset mid-run -> vetor 0000, running 0, no zero_pulse.
REQ-035 AUTO_RELOAD_EN: preset 0x0002, start, 2 ticks -> 0000 cycle replaced by 0002, zero_pulse 1, running stays 1.
